// File: rtl/p2p_target_wr_recv_if.sv
// p2p_target_wr_recv_if
//  Bundles the two streaming channels of the P2P write receive path.
//  Inbound request channel (tgt_req_*):
//    tgt_req_valid/last/head/data  from the PCIe side
//    tgt_req_ready                 back to the PCIe side
//  Outbound forward-down channel (p2p_down_*):
//    p2p_down_valid/last/head/data to the local device
//    p2p_down_ready                back from the local device
//  Modports:
//    slave  - the receive block (consumes tgt_req, produces p2p_down)
//    master - the environment around it
interface p2p_target_wr_recv_if #(
  parameter int DATA_W  = 256,
  parameter int HEAD_W  = 128,
  parameter int UHEAD_W = 64
);
  logic               tgt_req_valid;
  logic               tgt_req_last;
  logic [HEAD_W-1:0]  tgt_req_head;
  logic [DATA_W-1:0]  tgt_req_data;
  logic               tgt_req_ready;

  logic               p2p_down_valid;
  logic               p2p_down_last;
  logic [UHEAD_W-1:0] p2p_down_head;
  logic [DATA_W-1:0]  p2p_down_data;
  logic               p2p_down_ready;

  modport slave (
    input  tgt_req_valid, tgt_req_last, tgt_req_head, tgt_req_data,
    output tgt_req_ready,
    output p2p_down_valid, p2p_down_last, p2p_down_head, p2p_down_data,
    input  p2p_down_ready
  );

  modport master (
    output tgt_req_valid, tgt_req_last, tgt_req_head, tgt_req_data,
    input  tgt_req_ready,
    input  p2p_down_valid, p2p_down_last, p2p_down_head, p2p_down_data,
    output p2p_down_ready
  );
endinterface

// File: rtl/p2p_target_wr_recv.sv
// p2p_target_wr_recv
//  Target end of the P2P DMA write path. Inbound memory-write requests are
//  checked against the configured BAR window, the source slot is decoded from
//  the address, and each accepted request is repackaged onto the forward-down
//  channel. Out-of-window, disabled and zero-length requests are dropped and
//  counted; requests whose beat count disagrees with byte_len are counted and
//  either forwarded short or truncated at the expected beat count.
//  Ports:
//    clk, rst      clock, synchronous active-high reset
//    cfg_en        1 = forward in-window requests, 0 = drop everything
//    cfg_win_base  window base, bits [63:WIN_LOG2] compared
//    bus           slave side of p2p_target_wr_recv_if (tgt_req_*, p2p_down_*)
//    drop_cnt      saturating count of dropped requests
//    len_err_cnt   saturating count of length-mismatched requests
module p2p_target_wr_recv #(
  parameter int          DATA_W    = 256,
  parameter int          HEAD_W    = 128,
  parameter int          UHEAD_W   = 64,
  parameter int          WIN_LOG2  = 24,
  parameter int          SLOT_LOG2 = 16,
  parameter logic [7:0]  LOCAL_DEV = 8'h01
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_en,
  input  logic [63:0]          cfg_win_base,
  p2p_target_wr_recv_if.slave  bus,
  output logic [15:0]          drop_cnt,
  output logic [15:0]          len_err_cnt
);

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  localparam logic [63:0] WIN_MASK = (64'd1 << WIN_LOG2) - 64'd1;

  state_t               state;
  logic [8:0]           beat_cnt;
  logic [8:0]           exp_beats;

  logic                 out_valid;
  logic                 out_last;
  logic [UHEAD_W-1:0]   out_head;
  logic [DATA_W-1:0]    out_data;

  logic                 acc;
  logic [63:0]          req_addr;
  logic [12:0]          req_len;
  logic [7:0]           src_dev;
  logic                 win_hit;
  logic [8:0]           req_exp;
  logic [UHEAD_W-1:0]   first_head;

  logic                 emit;
  logic                 first;
  logic [8:0]           cur_cnt;
  logic [8:0]           cur_exp;
  logic                 at_exp;

  logic                 unused_head_bits;

  assign bus.tgt_req_ready  = ~rst & (~out_valid | bus.p2p_down_ready);
  assign bus.p2p_down_valid = out_valid;
  assign bus.p2p_down_last  = out_last;
  assign bus.p2p_down_head  = out_head;
  assign bus.p2p_down_data  = out_data;

  assign acc = bus.tgt_req_valid & bus.tgt_req_ready;

  // First-beat decode; only meaningful when state == IDLE.
  assign req_addr   = bus.tgt_req_head[95:32];
  assign req_len    = bus.tgt_req_head[12:0];
  assign src_dev    = 8'((req_addr & WIN_MASK) >> SLOT_LOG2);
  assign win_hit    = cfg_en
                    & ((req_addr >> WIN_LOG2) == (cfg_win_base >> WIN_LOG2))
                    & (req_len != 13'd0);
  assign req_exp    = 9'((14'(req_len) + 14'd31) >> 5);
  assign first_head = UHEAD_W'({16'h0, LOCAL_DEV, src_dev, 16'h0, 3'b0, req_len});

  assign unused_head_bits = &{1'b0, bus.tgt_req_head[127:96], bus.tgt_req_head[31:13]};

  // Per-beat decision: the first beat of a hit is judged with cnt=1 and the
  // freshly decoded expectation so the length rules apply uniformly.
  always_comb begin
    emit    = 1'b0;
    first   = 1'b0;
    cur_cnt = beat_cnt + 9'd1;
    cur_exp = exp_beats;
    case (state)
      IDLE: begin
        first   = 1'b1;
        emit    = win_hit;
        cur_cnt = 9'd1;
        cur_exp = req_exp;
      end
      FWD:     emit = 1'b1;
      default: emit = 1'b0;
    endcase
    at_exp = (cur_cnt == cur_exp);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      exp_beats   <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_head    <= '0;
      out_data    <= '0;
      drop_cnt    <= '0;
      len_err_cnt <= '0;
    end else begin
      if (bus.p2p_down_ready | ~out_valid)
        out_valid <= 1'b0;

      if (acc) begin
        case (state)
          IDLE: if (!win_hit) begin
            if (drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
            state <= bus.tgt_req_last ? IDLE : DROP;
          end
          DROP: if (bus.tgt_req_last) state <= IDLE;
          default: ;
        endcase

        if (emit) begin
          out_valid <= 1'b1;
          out_data  <= bus.tgt_req_data;
          out_head  <= first ? first_head : '0;
          out_last  <= bus.tgt_req_last | at_exp;
          beat_cnt  <= cur_cnt;
          exp_beats <= cur_exp;
          if (bus.tgt_req_last) begin
            state <= IDLE;
            if (!at_exp && len_err_cnt != '1) len_err_cnt <= len_err_cnt + 16'd1;
          end else if (at_exp) begin
            // Too many beats: close the packet here and swallow the rest.
            state <= DROP;
            if (len_err_cnt != '1) len_err_cnt <= len_err_cnt + 16'd1;
          end else begin
            state <= FWD;
          end
        end
      end
    end
  end

endmodule
